// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface constants and arbitration owner encoding used by the
// fetch/data memory arbiter and its bench.
package mem_arbiter_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int MEM_CMD_WIDTH = 2;

    localparam logic [1:0] MEM_CMD_READ  = 2'd0;
    localparam logic [1:0] MEM_CMD_WRITE = 2'd1;

    localparam logic ARB_OWNER_FETCH = 1'b0;
    localparam logic ARB_OWNER_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and the data stage; data has priority, a streak counter bounds fetch starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDRESS_WIDTH,
    parameter int DATA_W       = DATA_WIDTH,
    parameter int CMD_W        = MEM_CMD_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_f_valid,
    input  logic [ADDR_W-1:0] i_f_addr,
    input  logic              i_f_flush,
    output logic              o_f_ready,
    output logic              o_f_res_valid,
    output logic [DATA_W-1:0] o_f_data,
    input  logic              i_f_res_ready,
    input  logic              i_d_valid,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [CMD_W-1:0]  i_d_cmd,
    input  logic [DATA_W-1:0] i_d_data,
    output logic              o_d_ready,
    output logic              o_d_res_valid,
    output logic [DATA_W-1:0] o_d_data,
    input  logic              i_d_res_ready,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [CMD_W-1:0]  o_mem_cmd,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_res_ready,
    input  logic              i_mem_ready,
    input  logic              i_mem_res_valid,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy,
    output logic              o_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    state_t              state_r;
    logic                owner_r;
    logic                drop_r;
    logic [STREAK_W-1:0] streak_r;
    logic                mem_valid_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [CMD_W-1:0]    mem_cmd_r;
    logic [DATA_W-1:0]   mem_data_r;

    logic f_elig_s;
    logic d_win_s;
    logic f_win_s;
    logic mem_res_ready_s;
    logic res_hs_s;

    // Grant selection: data first unless fetch has waited out the streak limit.
    always_comb begin
        f_elig_s  = i_f_valid & ~i_f_flush;
        d_win_s   = i_d_valid & ~(f_elig_s & (streak_r == STREAK_MAX));
        f_win_s   = f_elig_s & ~d_win_s;
        o_d_ready = 1'b0;
        o_f_ready = 1'b0;
        if (state_r == ST_IDLE) begin
            o_d_ready = d_win_s;
            o_f_ready = f_win_s;
        end else begin
            o_d_ready = 1'b0;
            o_f_ready = 1'b0;
        end
    end

    // Response routing; a dropped fetch response is swallowed without stalling memory.
    always_comb begin
        mem_res_ready_s = 1'b0;
        o_f_res_valid   = 1'b0;
        o_d_res_valid   = 1'b0;
        if (state_r == ST_WAIT) begin
            if (drop_r) begin
                mem_res_ready_s = 1'b1;
            end else if (owner_r == ARB_OWNER_DATA) begin
                mem_res_ready_s = i_d_res_ready;
            end else begin
                mem_res_ready_s = i_f_res_ready;
            end
            if (owner_r == ARB_OWNER_DATA) begin
                o_d_res_valid = i_mem_res_valid & ~drop_r;
            end else begin
                o_f_res_valid = i_mem_res_valid & ~drop_r;
            end
        end else begin
            mem_res_ready_s = 1'b0;
        end
        res_hs_s = i_mem_res_valid & mem_res_ready_s;
    end

    assign o_f_data        = i_mem_data;
    assign o_d_data        = i_mem_data;
    assign o_mem_res_ready = mem_res_ready_s;
    assign o_mem_valid     = mem_valid_r;
    assign o_mem_addr      = mem_addr_r;
    assign o_mem_cmd       = mem_cmd_r;
    assign o_mem_data      = mem_data_r;
    assign o_busy          = (state_r != ST_IDLE);
    assign o_owner         = owner_r;

    // Transaction FSM, captured request fields, streak and drop tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            owner_r     <= ARB_OWNER_FETCH;
            drop_r      <= 1'b0;
            streak_r    <= '0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_cmd_r   <= CMD_W'(MEM_CMD_READ);
            mem_data_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (d_win_s) begin
                        mem_addr_r  <= i_d_addr;
                        mem_cmd_r   <= i_d_cmd;
                        mem_data_r  <= i_d_data;
                        owner_r     <= ARB_OWNER_DATA;
                        mem_valid_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                        if (f_elig_s) begin
                            streak_r <= (streak_r == STREAK_MAX) ? STREAK_MAX
                                                                 : streak_r + STREAK_W'(1);
                        end else begin
                            streak_r <= '0;
                        end
                    end else if (f_win_s) begin
                        mem_addr_r  <= i_f_addr;
                        mem_cmd_r   <= CMD_W'(MEM_CMD_READ);
                        mem_data_r  <= '0;
                        owner_r     <= ARB_OWNER_FETCH;
                        mem_valid_r <= 1'b1;
                        streak_r    <= '0;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if ((owner_r == ARB_OWNER_FETCH) && i_f_flush) begin
                        drop_r <= 1'b1;
                    end
                    if (i_mem_ready) begin
                        mem_valid_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if ((owner_r == ARB_OWNER_FETCH) && i_f_flush) begin
                        drop_r <= 1'b1;
                    end
                    // Handshake wins over a same-cycle flush: drop never outlives its transaction.
                    if (res_hs_s) begin
                        drop_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_valid_r <= 1'b0;
                    drop_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, memory responder,
// arbitration vector table, directed corner sequences and a randomized soak.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_f_valid, i_f_flush, i_f_res_ready;
    logic [31:0] i_f_addr;
    logic        o_f_ready, o_f_res_valid;
    logic [31:0] o_f_data;
    logic        i_d_valid, i_d_res_ready;
    logic [31:0] i_d_addr, i_d_data;
    logic [1:0]  i_d_cmd;
    logic        o_d_ready, o_d_res_valid;
    logic [31:0] o_d_data;
    logic        o_mem_valid, o_mem_res_ready;
    logic [31:0] o_mem_addr, o_mem_data;
    logic [1:0]  o_mem_cmd;
    logic        i_mem_ready, i_mem_res_valid;
    logic [31:0] i_mem_data;
    logic        o_busy, o_owner;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_f_valid(i_f_valid), .i_f_addr(i_f_addr), .i_f_flush(i_f_flush),
        .o_f_ready(o_f_ready), .o_f_res_valid(o_f_res_valid), .o_f_data(o_f_data),
        .i_f_res_ready(i_f_res_ready),
        .i_d_valid(i_d_valid), .i_d_addr(i_d_addr), .i_d_cmd(i_d_cmd), .i_d_data(i_d_data),
        .o_d_ready(o_d_ready), .o_d_res_valid(o_d_res_valid), .o_d_data(o_d_data),
        .i_d_res_ready(i_d_res_ready),
        .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_cmd(o_mem_cmd),
        .o_mem_data(o_mem_data), .o_mem_res_ready(o_mem_res_ready),
        .i_mem_ready(i_mem_ready), .i_mem_res_valid(i_mem_res_valid), .i_mem_data(i_mem_data),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    // Stimulus intent, applied to the DUT each cycle by step().
    logic        f_valid = 1'b0, f_flush = 1'b0, f_res_ready = 1'b1;
    logic [31:0] f_addr = 32'd0;
    logic        d_valid = 1'b0, d_res_ready = 1'b1;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic [1:0]  d_cmd = MEM_CMD_READ;
    logic        mem_rdy = 1'b1, junk_en = 1'b0, stale_force = 1'b0;
    int          mem_lat = 0;
    logic        mem_force_en = 1'b0;
    logic [31:0] mem_force = 32'd0;

    // Memory responder state.
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_resp = 32'd0;

    // Reference model: one transaction in flight, described by flags.
    bit          m_active = 1'b0, m_issued = 1'b0, m_drop = 1'b0, m_owner = 1'b0;
    int          m_streak = 0;
    logic [31:0] m_addr = 32'd0, m_data = 32'd0;
    logic [1:0]  m_cmd = MEM_CMD_READ;
    bit          f_acc, d_acc;
    bit          grants[$];
    int          f_vcyc = 0, d_vcyc = 0;
    logic [31:0] f_last = 32'd0;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic       f_valid;
        logic       f_flush;
        logic       d_valid;
        logic [1:0] d_cmd;
        logic       exp_f;
        logic       exp_d;
    } vec_t;
    vec_t tbl[12];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endfunction

    function automatic void bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: cycle budget expired", name);
    endfunction

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Compare DUT outputs against the model, then advance model and memory.
    function automatic void model_cycle();
        bit fe, dw, fw, rr, fv, dv;
        f_acc = 1'b0;
        d_acc = 1'b0;
        if (o_f_res_valid === 1'b1) begin f_vcyc++; f_last = o_f_data; end
        if (o_d_res_valid === 1'b1) d_vcyc++;
        if (!m_active) begin
            fe = i_f_valid && !i_f_flush;
            dw = i_d_valid && !(fe && m_streak == LIMIT);
            fw = fe && !dw;
            chk1("idle_f_ready", o_f_ready, fw);
            chk1("idle_d_ready", o_d_ready, dw);
            chk1("idle_mem_valid", o_mem_valid, 1'b0);
            chk1("idle_busy", o_busy, 1'b0);
            chk1("idle_mem_res_ready", o_mem_res_ready, 1'b0);
            chk1("idle_f_res_valid", o_f_res_valid, 1'b0);
            chk1("idle_d_res_valid", o_d_res_valid, 1'b0);
            if (dw) begin
                m_active = 1'b1; m_issued = 1'b0; m_owner = 1'b1;
                m_addr = i_d_addr; m_cmd = i_d_cmd; m_data = i_d_data;
                m_streak = fe ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                d_acc = 1'b1;
                grants.push_back(1'b1);
            end else if (fw) begin
                m_active = 1'b1; m_issued = 1'b0; m_owner = 1'b0;
                m_addr = i_f_addr; m_cmd = MEM_CMD_READ; m_data = 32'd0;
                m_streak = 0;
                f_acc = 1'b1;
                grants.push_back(1'b0);
            end
        end else if (!m_issued) begin
            chk1("issue_busy", o_busy, 1'b1);
            chk1("issue_owner", o_owner, m_owner);
            chk1("issue_mem_valid", o_mem_valid, 1'b1);
            chk("issue_addr", o_mem_addr, m_addr);
            chk("issue_cmd", 32'(o_mem_cmd), 32'(m_cmd));
            chk("issue_data", o_mem_data, m_data);
            chk1("issue_f_ready", o_f_ready, 1'b0);
            chk1("issue_d_ready", o_d_ready, 1'b0);
            chk1("issue_mem_res_ready", o_mem_res_ready, 1'b0);
            chk1("issue_f_res_valid", o_f_res_valid, 1'b0);
            chk1("issue_d_res_valid", o_d_res_valid, 1'b0);
            if (!m_owner && i_f_flush) m_drop = 1'b1;
            if (i_mem_ready) begin
                m_issued = 1'b1;
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_resp = mem_force_en ? mem_force :
                           (m_cmd == MEM_CMD_READ) ? rd_data(m_addr) : 32'd0;
            end
        end else begin
            rr = m_drop ? 1'b1 : (m_owner ? i_d_res_ready : i_f_res_ready);
            fv = !m_owner && i_mem_res_valid && !m_drop;
            dv = m_owner && i_mem_res_valid && !m_drop;
            chk1("wait_busy", o_busy, 1'b1);
            chk1("wait_owner", o_owner, m_owner);
            chk1("wait_mem_valid", o_mem_valid, 1'b0);
            chk1("wait_f_ready", o_f_ready, 1'b0);
            chk1("wait_d_ready", o_d_ready, 1'b0);
            chk1("wait_mem_res_ready", o_mem_res_ready, rr);
            chk1("wait_f_res_valid", o_f_res_valid, fv);
            chk1("wait_d_res_valid", o_d_res_valid, dv);
            if (fv) chk("wait_f_data", o_f_data, mem_resp);
            if (dv) chk("wait_d_data", o_d_data, mem_resp);
            if (!m_owner && i_f_flush) m_drop = 1'b1;
            if (i_mem_res_valid && rr) begin
                m_active = 1'b0;
                m_drop   = 1'b0;
                mem_pend = 1'b0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        i_f_valid = f_valid; i_f_addr = f_addr; i_f_flush = f_flush; i_f_res_ready = f_res_ready;
        i_d_valid = d_valid; i_d_addr = d_addr; i_d_cmd = d_cmd; i_d_data = d_wdata;
        i_d_res_ready = d_res_ready; i_mem_ready = mem_rdy;
        if (mem_pend) begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                i_mem_res_valid = 1'b0;
                i_mem_data = $urandom;
            end else begin
                i_mem_res_valid = 1'b1;
                i_mem_data = mem_resp;
            end
        end else begin
            i_mem_res_valid = stale_force || (junk_en && ($urandom_range(0, 3) == 0));
            i_mem_data = $urandom;
        end
        @(negedge clk);
        model_cycle();
    endtask

    task automatic run_idle(input string name, input int max_cyc);
        int n = 0;
        while (m_active && n < max_cyc) begin
            step();
            n++;
        end
        if (m_active) bound_fail(name);
    endtask

    // which: 0 = fetch accepted, 1 = data accepted, 2 = memory took request
    task automatic wait_for(input string name, input int which, input int max_cyc);
        bit hit = 1'b0;
        for (int n = 0; n < max_cyc && !hit; n++) begin
            step();
            hit = (which == 0) ? f_acc : (which == 1) ? d_acc : m_issued;
        end
        if (!hit) bound_fail(name);
    endtask

    initial begin
        bit exp3[10];
        int fv0, dv0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, MEM_CMD_READ,  1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, MEM_CMD_WRITE, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, MEM_CMD_READ,  1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, MEM_CMD_WRITE, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, MEM_CMD_READ,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, MEM_CMD_READ,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, MEM_CMD_READ,  1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, MEM_CMD_WRITE, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, MEM_CMD_READ,  1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, MEM_CMD_WRITE, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, MEM_CMD_READ,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, MEM_CMD_READ,  1'b0, 1'b1};
        exp3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b0;
        i_f_valid = 1'b0; i_f_addr = 32'd0; i_f_flush = 1'b0; i_f_res_ready = 1'b1;
        i_d_valid = 1'b0; i_d_addr = 32'd0; i_d_cmd = MEM_CMD_READ; i_d_data = 32'd0;
        i_d_res_ready = 1'b1; i_mem_ready = 1'b1; i_mem_res_valid = 1'b0; i_mem_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_owner", o_owner, 1'b0);
        chk1("rst_mem_valid", o_mem_valid, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_cmd", 32'(o_mem_cmd), 32'(MEM_CMD_READ));
        chk("rst_mem_data", o_mem_data, 32'd0);
        chk1("rst_mem_res_ready", o_mem_res_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Arbitration table: one IDLE decision per row, loser withdrawn afterwards.
        for (int i = 0; i < 12; i++) begin
            f_valid = tbl[i].f_valid; f_flush = tbl[i].f_flush; d_valid = tbl[i].d_valid;
            d_cmd = tbl[i].d_cmd;
            f_addr = 32'h1000 + 32'(i * 4); d_addr = 32'h2000 + 32'(i * 4); d_wdata = 32'hA000 + 32'(i);
            mem_lat = i % 3;
            step();
            chk1("tbl_f_ready", o_f_ready, tbl[i].exp_f);
            chk1("tbl_d_ready", o_d_ready, tbl[i].exp_d);
            f_valid = 1'b0; d_valid = 1'b0; f_flush = 1'b0;
            run_idle("tbl_idle", 40);
        end

        // Lone fetch read answered with a fixed word two cycles after issue.
        mem_force_en = 1'b1; mem_force = 32'hDEAD_BEEF; mem_lat = 2;
        f_valid = 1'b1; f_addr = 32'h100;
        wait_for("s1_accept", 0, 10);
        f_valid = 1'b0;
        fv0 = f_vcyc; dv0 = d_vcyc;
        run_idle("s1_idle", 30);
        chk("s1_f_res_count", 32'(f_vcyc - fv0), 32'd1);
        chk("s1_d_res_count", 32'(d_vcyc - dv0), 32'd0);
        chk("s1_f_data", f_last, 32'hDEAD_BEEF);
        mem_force_en = 1'b0;

        // Simultaneous fetch and data write: data first, ack only on data side.
        grants.delete();
        mem_lat = 1;
        f_valid = 1'b1; f_addr = 32'h180;
        d_valid = 1'b1; d_cmd = MEM_CMD_WRITE; d_addr = 32'h200; d_wdata = 32'h55;
        fv0 = f_vcyc; dv0 = d_vcyc;
        for (int n = 0; n < 40 && (grants.size() < 2 || m_active); n++) begin
            step();
            if (f_acc) f_valid = 1'b0;
            if (d_acc) d_valid = 1'b0;
        end
        if (grants.size() != 2 || m_active) bound_fail("s2_done");
        else begin
            chk1("s2_first_data", grants[0], 1'b1);
            chk1("s2_second_fetch", grants[1], 1'b0);
        end
        chk("s2_d_acks", 32'(d_vcyc - dv0), 32'd1);
        chk("s2_f_res", 32'(f_vcyc - fv0), 32'd1);

        // Both always requesting: starvation limit forces every fifth grant to fetch.
        grants.delete();
        mem_lat = 0; d_cmd = MEM_CMD_READ;
        f_valid = 1'b1; d_valid = 1'b1;
        for (int n = 0; n < 200 && grants.size() < 10; n++) step();
        f_valid = 1'b0; d_valid = 1'b0;
        run_idle("s3_idle", 20);
        if (grants.size() < 10) bound_fail("s3_grants");
        else for (int k = 0; k < 10; k++) chk1($sformatf("s3_grant%0d", k), grants[k], exp3[k]);

        // Flush in WAIT with fetch not ready: response consumed silently.
        mem_lat = 3; f_res_ready = 1'b0;
        f_valid = 1'b1; f_addr = 32'h400;
        wait_for("s4_accept", 0, 10);
        f_valid = 1'b0;
        wait_for("s4_issue", 2, 10);
        fv0 = f_vcyc;
        f_flush = 1'b1;
        step();
        f_flush = 1'b0;
        run_idle("s4_idle", 30);
        chk("s4_no_f_res", 32'(f_vcyc - fv0), 32'd0);
        step();
        chk1("s4_busy", o_busy, 1'b0);
        f_res_ready = 1'b1;

        // Memory stalls in ISSUE, then data owner stalls the response.
        mem_rdy = 1'b0; mem_lat = 0;
        d_valid = 1'b1; d_cmd = MEM_CMD_READ; d_addr = 32'h300;
        wait_for("s5_accept", 1, 10);
        d_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("s5_mem_valid_held", o_mem_valid, 1'b1);
            chk("s5_mem_addr_held", o_mem_addr, 32'h300);
        end
        mem_rdy = 1'b1; d_res_ready = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            chk1("s5_res_ready_low", o_mem_res_ready, 1'b0);
            chk1("s5_d_res_held", o_d_res_valid, 1'b1);
        end
        d_res_ready = 1'b1;
        run_idle("s5_idle", 10);

        // Reset during WAIT, then a stale memory response.
        mem_lat = 6;
        f_valid = 1'b1; f_addr = 32'h500;
        wait_for("s6_accept", 0, 10);
        f_valid = 1'b0;
        wait_for("s6_issue", 2, 10);
        step();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk1("s6_busy", o_busy, 1'b0);
        chk1("s6_owner", o_owner, 1'b0);
        chk1("s6_mem_valid", o_mem_valid, 1'b0);
        chk("s6_mem_addr", o_mem_addr, 32'd0);
        chk1("s6_f_res_valid", o_f_res_valid, 1'b0);
        chk1("s6_mem_res_ready", o_mem_res_ready, 1'b0);
        m_active = 1'b0; m_issued = 1'b0; m_drop = 1'b0; m_streak = 0; mem_pend = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        stale_force = 1'b1;
        step();
        chk1("s6_stale_ignored", o_mem_res_ready, 1'b0);
        step();
        stale_force = 1'b0;

        // Randomized soak against the model.
        junk_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!f_valid && $urandom_range(0, 2) == 0) begin f_valid = 1'b1; f_addr = $urandom; end
            if (!d_valid && $urandom_range(0, 2) == 0) begin
                d_valid = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_cmd = ($urandom_range(0, 1) == 0) ? MEM_CMD_READ : MEM_CMD_WRITE;
            end
            f_flush = ($urandom_range(0, 9) == 0);
            f_res_ready = ($urandom_range(0, 3) != 0);
            d_res_ready = ($urandom_range(0, 3) != 0);
            mem_rdy = ($urandom_range(0, 2) != 0);
            mem_lat = $urandom_range(0, 3);
            step();
            if (f_acc) f_valid = 1'b0;
            if (d_acc) d_valid = 1'b0;
        end
        f_valid = 1'b0; d_valid = 1'b0; f_flush = 1'b0; junk_en = 1'b0;
        f_res_ready = 1'b1; d_res_ready = 1'b1; mem_rdy = 1'b1;
        run_idle("rand_drain", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
